// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - datapath-facing signals between sequencer and program datapath
interface fetch_sequencer_if;
  logic [7:0]  rom_data;
  logic [3:0]  instr;
  logic [3:0]  operand;
  logic        carry;
  logic        zero;
  logic        enablec;
  logic        enablef;
  logic        load;
  logic [11:0] load_data;
  logic        exec_strobe;

  modport master (
    input  rom_data, instr, operand, carry, zero,
    output enablec, enablef, load, load_data, exec_strobe
  );

  modport slave (
    output rom_data, instr, operand, carry, zero,
    input  enablec, enablef, load, load_data, exec_strobe
  );
endinterface

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch/execute sequencer with jump resolution, run/halt/step control
module fetch_sequencer #(
  parameter logic [11:0] RESET_VECTOR = 12'h000,
  parameter int          CNT_W        = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               halt_req,
  input  logic               step_mode,
  input  logic               step,
  fetch_sequencer_if.master  dp,
  output logic [2:0]         state,
  output logic               halted,
  output logic [CNT_W-1:0]   icount
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_PAUSE = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam logic [3:0] OP_JC  = 4'h0;
  localparam logic [3:0] OP_JNC = 4'h1;
  localparam logic [3:0] OP_JMP = 4'h2;
  localparam logic [3:0] OP_JZ  = 4'h3;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   icount_q, icount_d;
  logic               halted_q;
  logic               is_jump;
  logic               taken;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      icount_q <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      icount_q <= icount_d;
      halted_q <= (state_d == S_HALT);
    end
  end

  // Jump class decode; flags only matter during EXEC since outputs are gated by state.
  always_comb begin
    is_jump = 1'b0;
    taken   = 1'b0;
    case (dp.instr)
      OP_JC:   begin is_jump = 1'b1; taken = dp.carry;  end
      OP_JNC:  begin is_jump = 1'b1; taken = !dp.carry; end
      OP_JMP:  begin is_jump = 1'b1; taken = 1'b1;      end
      OP_JZ:   begin is_jump = 1'b1; taken = dp.zero;   end
      default: begin is_jump = 1'b0; taken = 1'b0;      end
    endcase
  end

  always_comb begin
    state_d         = state_q;
    icount_d        = icount_q;
    dp.enablec      = 1'b0;
    dp.enablef      = 1'b0;
    dp.load         = 1'b0;
    dp.load_data    = 12'h000;
    dp.exec_strobe  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          dp.load      = 1'b1;
          dp.load_data = RESET_VECTOR;
          state_d      = S_FETCH;
        end
      end
      S_FETCH: begin
        dp.enablef = 1'b1;
        dp.enablec = 1'b1;
        state_d    = S_EXEC;
      end
      S_EXEC: begin
        if (is_jump) begin
          // Second byte of a jump sits at the already-incremented PC.
          if (taken) begin
            dp.load      = 1'b1;
            dp.load_data = {dp.operand, dp.rom_data};
          end else begin
            dp.enablec = 1'b1;
          end
        end else if (dp.instr != OP_HLT) begin
          dp.exec_strobe = 1'b1;
        end
        if (icount_q != {CNT_W{1'b1}}) begin
          icount_d = icount_q + 1'b1;
        end
        if ((dp.instr == OP_HLT) || halt_req) begin
          state_d = S_HALT;
        end else if (step_mode) begin
          state_d = S_PAUSE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_PAUSE: begin
        if (halt_req) begin
          state_d = S_HALT;
        end else if (step) begin
          state_d = S_FETCH;
        end
      end
      S_HALT: begin
        if (start) begin
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign state  = state_q;
  assign halted = halted_q;
  assign icount = icount_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed bench with behavioural PC/ROM/fetch-register datapath
module tb_fetch_sequencer;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        halt_req = 1'b0;
  logic        step_mode = 1'b0;
  logic        step = 1'b0;
  logic        start2 = 1'b0;
  logic [2:0]  state, state2;
  logic        halted, halted2;
  logic [15:0] icount;
  logic [1:0]  icount2;

  logic [7:0]  rom [0:4095];
  logic [11:0] pc = 12'h000;
  logic [7:0]  ir = 8'h00;
  logic        carry = 1'b0;
  logic        zero = 1'b0;

  int errors = 0;
  int checks = 0;

  fetch_sequencer_if dp ();
  fetch_sequencer_if dp2 ();

  always #5 clock = ~clock;

  assign dp.rom_data = rom[pc];
  assign dp.instr    = ir[7:4];
  assign dp.operand  = ir[3:0];
  assign dp.carry    = carry;
  assign dp.zero     = zero;

  assign dp2.rom_data = 8'h00;
  assign dp2.instr    = 4'h5;
  assign dp2.operand  = 4'h0;
  assign dp2.carry    = 1'b0;
  assign dp2.zero     = 1'b0;

  always @(posedge clock) begin
    if (dp.load)         pc <= dp.load_data;
    else if (dp.enablec) pc <= pc + 12'd1;
    if (dp.enablef)      ir <= rom[pc];
  end

  fetch_sequencer #(.RESET_VECTOR(12'h000), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .start(start), .halt_req(halt_req),
    .step_mode(step_mode), .step(step), .dp(dp),
    .state(state), .halted(halted), .icount(icount)
  );

  fetch_sequencer #(.RESET_VECTOR(12'h000), .CNT_W(2)) dut_sat (
    .clock(clock), .reset(reset), .start(start2), .halt_req(1'b0),
    .step_mode(1'b0), .step(1'b0), .dp(dp2),
    .state(state2), .halted(halted2), .icount(icount2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_rom(input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3);
    for (int i = 0; i < 4096; i++) rom[i] = 8'hF0;
    rom[0] = b0; rom[1] = b1; rom[2] = b2; rom[3] = b3;
  endtask

  task automatic do_reset();
    reset = 1'b0; start = 1'b0; halt_req = 1'b0; step_mode = 1'b0; step = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic kick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    // 1: reset state and vector load
    load_rom(8'h45, 8'h67, 8'hF0, 8'h00);
    do_reset();
    check("rst_state", state, 3'd0);
    check("rst_enables", {dp.enablec, dp.enablef, dp.load, dp.exec_strobe}, 4'b0000);
    check("rst_load_data", dp.load_data, 12'h000);
    check("rst_icount", icount, 16'd0);
    check("rst_halted", halted, 1'b0);
    start = 1'b1;
    #1;
    check("start_load", dp.load, 1'b1);
    check("start_vector", dp.load_data, 12'h000);
    tick();
    start = 1'b0;
    check("fetch_state", state, 3'd1);

    // 2: two ALU ops then HLT
    check("fetch_en", {dp.enablef, dp.enablec}, 2'b11);
    tick();
    check("exec0_state", state, 3'd2);
    check("exec0_strobe", dp.exec_strobe, 1'b1);
    tick();
    check("fetch1_state", state, 3'd1);
    tick();
    check("exec1_strobe", dp.exec_strobe, 1'b1);
    check("exec1_ir", ir, 8'h67);
    tick();
    tick();
    check("hlt_outputs", {dp.enablec, dp.enablef, dp.load, dp.exec_strobe}, 4'b0000);
    tick();
    check("hlt_state", state, 3'd4);
    check("hlt_halted", halted, 1'b1);
    check("hlt_icount", icount, 16'd3);
    check("hlt_pc", pc, 12'h003);

    // 3: JMP 0xABC
    load_rom(8'h2A, 8'hBC, 8'h00, 8'h00);
    do_reset();
    kick();
    tick();
    check("jmp_load", dp.load, 1'b1);
    check("jmp_target", dp.load_data, 12'hABC);
    check("jmp_no_inc", dp.enablec, 1'b0);
    tick();
    check("jmp_pc", pc, 12'hABC);
    check("jmp_icount", icount, 16'd1);
    tick();
    check("jmp_fetched", ir, 8'hF0);

    // 4: JC not taken, then taken
    load_rom(8'h01, 8'h20, 8'h50, 8'hF0);
    carry = 1'b0;
    do_reset();
    kick();
    tick();
    check("jc_nt_enc", dp.enablec, 1'b1);
    check("jc_nt_load", dp.load, 1'b0);
    tick();
    check("jc_nt_pc", pc, 12'h002);
    tick();
    check("jc_nt_next", ir, 8'h50);
    carry = 1'b1;
    do_reset();
    kick();
    tick();
    check("jc_t_load", dp.load, 1'b1);
    check("jc_t_target", dp.load_data, 12'h120);
    check("jc_t_enc", dp.enablec, 1'b0);
    carry = 1'b0;

    // 5: single-step, halt_req beats step in PAUSE
    load_rom(8'h50, 8'h51, 8'hF0, 8'hF0);
    do_reset();
    step_mode = 1'b1;
    kick();
    tick();
    tick();
    check("step_pause", state, 3'd3);
    tick(); tick();
    check("step_hold", state, 3'd3);
    check("step_icount", icount, 16'd1);
    step = 1'b1;
    tick();
    step = 1'b0;
    check("step_fetch", state, 3'd1);
    check("step_pc", pc, 12'h001);
    tick();
    check("step_ir", ir, 8'h51);
    tick();
    check("step_pause2", state, 3'd3);
    step = 1'b1; halt_req = 1'b1;
    tick();
    step = 1'b0; halt_req = 1'b0;
    check("step_halt", state, 3'd4);
    step_mode = 1'b0;

    // 6: async reset during EXEC of JMP
    load_rom(8'h50, 8'h2A, 8'hBC, 8'h00);
    do_reset();
    kick();
    tick(); tick(); tick();
    check("ar_pre_load", dp.load, 1'b1);
    check("ar_pre_icount", icount, 16'd1);
    #1 reset = 1'b0;
    #1;
    check("ar_load", dp.load, 1'b0);
    check("ar_load_data", dp.load_data, 12'h000);
    check("ar_state", state, 3'd0);
    check("ar_icount", icount, 16'd0);
    tick();
    reset = 1'b1;

    // icount saturation on a 2-bit counter
    tick();
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("sat_two", icount2, 2'd2);
    tick(); tick();
    check("sat_three", icount2, 2'd3);
    for (int i = 0; i < 6; i++) tick();
    check("sat_hold", icount2, 2'd3);
    check("sat_running", state2, 3'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
